// File: rtl/factorial_core.sv
// Iterative factorial engine: n! mod 2^W, one radix-2 shift-add multiply per factor
// (n, n-1, ..., 2), result presented with a one-cycle done pulse.
module factorial_core #(
    parameter int W   = 32,
    parameter int N_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N_W-1:0] n,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   result,
    output logic           overflow
);

    // Handshake: start/n are taken only while busy=0 (IDLE); a start seen while busy
    // is dropped. done is a single-cycle strobe, result/overflow stay stable until the next done.
    localparam int PP_W  = W + N_W;
    localparam int IDX_W = (N_W > 1) ? $clog2(N_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NEXT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [W-1:0]      acc, acc_nxt;
    logic [N_W-1:0]    cnt, cnt_nxt;
    logic [PP_W-1:0]   pp, pp_nxt;
    logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
    logic              ovf_acc, ovf_acc_nxt;
    logic [W-1:0]      result_nxt;
    logic              overflow_nxt;

    logic [PP_W-1:0]   acc_ext;
    logic [N_W-1:0]    cnt_dec;
    logic              ovf_new;

    assign acc_ext = PP_W'(acc);
    assign cnt_dec = cnt - N_W'(1);
    // Anything above bit W-1 of the finished product means the factor did not fit.
    assign ovf_new = ovf_acc | (pp[PP_W-1:W] != '0);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            pp       <= '0;
            bit_idx  <= '0;
            ovf_acc  <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            cnt      <= cnt_nxt;
            pp       <= pp_nxt;
            bit_idx  <= bit_idx_nxt;
            ovf_acc  <= ovf_acc_nxt;
            result   <= result_nxt;
            overflow <= overflow_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        cnt_nxt      = cnt;
        pp_nxt       = pp;
        bit_idx_nxt  = bit_idx;
        ovf_acc_nxt  = ovf_acc;
        result_nxt   = result;
        overflow_nxt = overflow;

        case (state)
            IDLE: begin
                if (start) begin
                    cnt_nxt     = n;
                    acc_nxt     = W'(1);
                    pp_nxt      = '0;
                    bit_idx_nxt = '0;
                    ovf_acc_nxt = 1'b0;
                    if (n <= N_W'(1)) begin
                        result_nxt   = W'(1);
                        overflow_nxt = 1'b0;
                        state_nxt    = DONE;
                    end else begin
                        state_nxt = MUL;
                    end
                end
            end
            MUL: begin
                if (cnt[bit_idx]) begin
                    pp_nxt = pp + (acc_ext << bit_idx);
                end
                bit_idx_nxt = bit_idx + IDX_W'(1);
                if (bit_idx == IDX_W'(N_W - 1)) begin
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                acc_nxt     = pp[W-1:0];
                ovf_acc_nxt = ovf_new;
                cnt_nxt     = cnt_dec;
                if (cnt_dec <= N_W'(1)) begin
                    result_nxt   = pp[W-1:0];
                    overflow_nxt = ovf_new;
                    state_nxt    = DONE;
                end else begin
                    pp_nxt      = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = MUL;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_factorial_core.sv
// Directed bench for factorial_core (W=32, N_W=8): reset, small operands, latency,
// wrap/overflow, mid-run reset and back-to-back operation.
module tb_factorial_core;

    localparam int W      = 32;
    localparam int N_W    = 8;
    localparam int BUDGET = 2000;

    logic           clk;
    logic           reset;
    logic           start;
    logic [N_W-1:0] n;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           overflow;

    int checks;
    int failures;

    factorial_core #(.W(W), .N_W(N_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .n        (n),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled and inputs changed 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start with operand nv. edges counts the accept edge as 1 and stops at the
    // first edge after which done is observed high, or at the budget.
    task automatic run_op(input logic [N_W-1:0] nv, output int edges, output logic got);
        start = 1'b1;
        n     = nv;
        tick();
        start = 1'b0;
        edges = 1;
        while (done !== 1'b1 && edges < BUDGET) begin
            tick();
            edges++;
        end
        got = (done === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        n     = 8'd5;
        tick();
        tick();
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)       begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 32'd0)    begin failures++; $display("FAIL reset_result got=%0h exp=0", result); end
        checks++; if (overflow !== 1'b0)   begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        reset = 1'b0;
        start = 1'b0;
        tick();
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_no_start got=%b exp=0", busy); end
    endtask

    task automatic test_small(input logic [N_W-1:0] nv);
        int   edges;
        logic got;
        run_op(nv, edges, got);
        checks++; if (!got || edges != 1)  begin failures++; $display("FAIL small_n%0d_latency got=%0d exp=1", nv, edges); end
        checks++; if (result !== 32'd1)    begin failures++; $display("FAIL small_n%0d_result got=%0h exp=1", nv, result); end
        checks++; if (overflow !== 1'b0)   begin failures++; $display("FAIL small_n%0d_overflow got=%b exp=0", nv, overflow); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL small_n%0d_pulse done=%b busy=%b exp=0/0", nv, done, busy);
        end
    endtask

    // n=5 with a stray start(n=3) at edge 10 that must be ignored.
    task automatic test_n5_ignore_start();
        int edges;
        start = 1'b1;
        n     = 8'd5;
        tick();
        start = 1'b0;
        edges = 1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL n5_busy got=%b exp=1", busy); end
        while (done !== 1'b1 && edges < BUDGET) begin
            if (edges == 9) begin
                start = 1'b1;
                n     = 8'd3;
            end else begin
                start = 1'b0;
            end
            tick();
            edges++;
        end
        start = 1'b0;
        checks++; if (done !== 1'b1 || edges != 37) begin failures++; $display("FAIL n5_latency got=%0d exp=37", edges); end
        checks++; if (result !== 32'd120) begin failures++; $display("FAIL n5_result got=%0d exp=120", result); end
        checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL n5_overflow got=%b exp=0", overflow); end
        tick();
    endtask

    task automatic test_wide();
        int   edges;
        logic got;
        run_op(8'd12, edges, got);
        checks++; if (!got || edges != 100)     begin failures++; $display("FAIL n12_latency got=%0d exp=100", edges); end
        checks++; if (result !== 32'h1C8CFC00) begin failures++; $display("FAIL n12_result got=%0h exp=1c8cfc00", result); end
        checks++; if (overflow !== 1'b0)        begin failures++; $display("FAIL n12_overflow got=%b exp=0", overflow); end
        tick();
        run_op(8'd13, edges, got);
        checks++; if (!got || edges != 109)     begin failures++; $display("FAIL n13_latency got=%0d exp=109", edges); end
        checks++; if (result !== 32'h7328CC00) begin failures++; $display("FAIL n13_result got=%0h exp=7328cc00", result); end
        checks++; if (overflow !== 1'b1)        begin failures++; $display("FAIL n13_overflow got=%b exp=1", overflow); end
        tick();
    endtask

    task automatic test_reset_mid();
        int   edges;
        int   seen_done;
        logic got;
        seen_done = 0;
        start = 1'b1;
        n     = 8'd12;
        tick();
        start = 1'b0;
        for (int i = 1; i < 20; i++) begin
            if (done === 1'b1) seen_done++;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if (done === 1'b1) seen_done++;
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
        checks++; if (result !== 32'd0)   begin failures++; $display("FAIL mid_reset_result got=%0h exp=0", result); end
        checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL mid_reset_overflow got=%b exp=0", overflow); end
        checks++; if (seen_done != 0)     begin failures++; $display("FAIL mid_reset_done got=%0d exp=0", seen_done); end
        run_op(8'd4, edges, got);
        checks++; if (!got || edges != 28) begin failures++; $display("FAIL n4_latency got=%0d exp=28", edges); end
        checks++; if (result !== 32'd24)   begin failures++; $display("FAIL n4_result got=%0d exp=24", result); end
        tick();
    endtask

    task automatic test_back_to_back();
        int   edges;
        logic got;
        run_op(8'd3, edges, got);
        checks++; if (!got || edges != 19) begin failures++; $display("FAIL b2b_n3_latency got=%0d exp=19", edges); end
        checks++; if (result !== 32'd6)    begin failures++; $display("FAIL b2b_n3_result got=%0d exp=6", result); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL b2b_pulse done=%b busy=%b exp=0/0", done, busy);
        end
        start = 1'b1;
        n     = 8'd2;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || result !== 32'd6) begin
            failures++; $display("FAIL b2b_hold busy=%b result=%0d exp=1/6", busy, result);
        end
        edges = 1;
        while (done !== 1'b1 && edges < BUDGET) begin
            tick();
            edges++;
        end
        checks++; if (done !== 1'b1 || edges != 10) begin failures++; $display("FAIL b2b_n2_latency got=%0d exp=10", edges); end
        checks++; if (result !== 32'd2) begin failures++; $display("FAIL b2b_n2_result got=%0d exp=2", result); end
        tick();
        checks++; if (done !== 1'b0 || result !== 32'd2) begin
            failures++; $display("FAIL b2b_end done=%b result=%0d exp=0/2", done, result);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        start    = 1'b0;
        n        = '0;
        #1;
        test_reset();
        test_small(8'd0);
        test_small(8'd1);
        test_n5_ignore_start();
        test_wide();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
